rank_filter_frame_ctrl: RTL and testbench

- Frame-level sequencer for the 3x3 rank-order filter datapath.
- On a start command it raster-scans a IMG_W x IMG_H image one pixel per enabled cycle. For each pixel it drives the window-centre row/col to the address decoder and a clock enable to the datapath.
- It tracks each issued pixel through the fixed datapath latency, then issues the write strobe and write address to the result buffer.
- It latches the rank order for the whole frame and reports busy/done to the host.

---
 rtl/rank_filter_pkg.sv | 18 +
 rtl/rank_filter_lat_track.sv | 43 ++++
 rtl/rank_filter_frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_rank_filter_frame_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rank_filter_pkg.sv
// rtl/rank_filter_pkg.sv - shared types and constants for the rank-order filter frame sequencer
package rank_filter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ORDER_MIN = 1;
  localparam int ORDER_MAX = 9;
  localparam int ORDER_RST = 5;

  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;

endpackage

// File: rtl/rank_filter_lat_track.sv
// rtl/rank_filter_lat_track.sv - enable-gated valid/address delay line matching the datapath latency
module rank_filter_lat_track
  import rank_filter_pkg::*;
#(
  parameter int PIPE_LAT = 4,
  parameter int ADDR_W   = 13
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iClr,
  input  logic              iEn,
  input  logic              iValid,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              oValid,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oEmpty
);

  logic [PIPE_LAT-1:0] vld;
  logic [ADDR_W-1:0]   addr [PIPE_LAT];

  // Addresses are left in place on a flush; only the valid bits matter downstream.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      vld <= '0;
      for (int i = 0; i < PIPE_LAT; i++) addr[i] <= '0;
    end else if (iClr) begin
      vld <= '0;
    end else if (iEn) begin
      vld[0]  <= iValid;
      addr[0] <= iAddr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld[i]  <= vld[i-1];
        addr[i] <= addr[i-1];
      end
    end
  end

  assign oValid = vld[PIPE_LAT-1];
  assign oAddr  = addr[PIPE_LAT-1];
  assign oEmpty = ~|vld;

endmodule

// File: rtl/rank_filter_frame_ctrl.sv
// rtl/rank_filter_frame_ctrl.sv - frame sequencer: raster scan, datapath enable, result write tracking
module rank_filter_frame_ctrl
  import rank_filter_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int COORD_W  = 6,
  parameter int ADDR_W   = 13,
  parameter int PIPE_LAT = 4,
  parameter int ORDER_W  = 4
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iStart,
  input  logic               iAbort,
  input  logic [ORDER_W-1:0] iOrder,
  input  logic               iOutReady,
  output logic               oEn,
  output logic               oIssue,
  output logic [COORD_W-1:0] oRow,
  output logic [COORD_W-1:0] oCol,
  output logic [ORDER_W-1:0] oOrder,
  output logic               oWrite,
  output logic [ADDR_W-1:0]  oWrAddr,
  output logic               oBusy,
  output logic               oDone
);

  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 1);

  state_t              state, stateNext;
  logic [COORD_W-1:0]  row, col;
  logic [ADDR_W-1:0]   pixAddr, trkAddr, wrAddrQ;
  logic                trkValid, trkEmpty;
  logic                startAcc, flush, lastPix;
  logic [ORDER_W-1:0]  orderClamp, orderQ;

  assign lastPix = (row == ROW_LAST) && (col == COL_LAST);
  assign pixAddr = {{(ADDR_W - 2*COORD_W){1'b0}}, row, col};

  always_comb begin
    orderClamp = iOrder;
    if (iOrder < ORDER_W'(ORDER_MIN))      orderClamp = ORDER_W'(ORDER_MIN);
    else if (iOrder > ORDER_W'(ORDER_MAX)) orderClamp = ORDER_W'(ORDER_MAX);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNext;
  end

  // Abort beats stall: the abort cycle neither enables the datapath nor writes.
  always_comb begin
    stateNext = state;
    oEn       = 1'b0;
    oIssue    = 1'b0;
    startAcc  = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (iStart && !iAbort) begin
          startAcc  = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (iAbort) begin
          flush     = 1'b1;
          stateNext = IDLE;
        end else begin
          oEn    = iOutReady;
          oIssue = iOutReady;
          if (iOutReady && lastPix) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (iAbort) begin
          flush     = 1'b1;
          stateNext = IDLE;
        end else begin
          oEn = iOutReady;
          if (iOutReady && trkEmpty) stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      row <= '0;
      col <= '0;
    end else if (startAcc || flush) begin
      row <= '0;
      col <= '0;
    end else if (oIssue) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)       orderQ <= ORDER_W'(ORDER_RST);
    else if (startAcc) orderQ <= orderClamp;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)     wrAddrQ <= '0;
    else if (oWrite) wrAddrQ <= trkAddr;
  end

  rank_filter_lat_track #(
    .PIPE_LAT (PIPE_LAT),
    .ADDR_W   (ADDR_W)
  ) uLatTrack (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iClr   (flush),
    .iEn    (oEn),
    .iValid (oIssue),
    .iAddr  (pixAddr),
    .oValid (trkValid),
    .oAddr  (trkAddr),
    .oEmpty (trkEmpty)
  );

  assign oWrite  = trkValid & oEn;
  assign oWrAddr = oWrite ? trkAddr : wrAddrQ;
  assign oRow    = row;
  assign oCol    = col;
  assign oOrder  = orderQ;
  assign oBusy   = (state == RUN) || (state == DRAIN);
  assign oDone   = (state == DONE);

endmodule

// File: tb/tb_rank_filter_frame_ctrl.sv
// tb/tb_rank_filter_frame_ctrl.sv - randomized bench for the frame sequencer against a queue-based model
module tb_rank_filter_frame_ctrl;
  import rank_filter_pkg::*;

  localparam int IMG_W    = 64;
  localparam int IMG_H    = 64;
  localparam int COORD_W  = 6;
  localparam int ADDR_W   = 13;
  localparam int PIPE_LAT = 4;
  localparam int ORDER_W  = 4;
  localparam int NPIX     = IMG_W * IMG_H;

  logic               iClk = 1'b0;
  logic               iRst_n = 1'b0;
  logic               iStart = 1'b0;
  logic               iAbort = 1'b0;
  logic [ORDER_W-1:0] iOrder = '0;
  logic               iOutReady = 1'b0;
  logic               oEn, oIssue, oWrite, oBusy, oDone;
  logic [COORD_W-1:0] oRow, oCol;
  logic [ORDER_W-1:0] oOrder;
  logic [ADDR_W-1:0]  oWrAddr;

  always #5 iClk = ~iClk;

  rank_filter_frame_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W),
    .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT), .ORDER_W(ORDER_W)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iAbort(iAbort),
    .iOrder(iOrder), .iOutReady(iOutReady), .oEn(oEn), .oIssue(oIssue),
    .oRow(oRow), .oCol(oCol), .oOrder(oOrder), .oWrite(oWrite),
    .oWrAddr(oWrAddr), .oBusy(oBusy), .oDone(oDone)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 scanning, 2 draining, 3 done; in-flight pixels with their enabled-cycle age.
  int mMode, mNext, mOrder, mLast;
  int qAddr[$];
  int qAge[$];
  bit eEn, eIssue, eWrite, eDone;
  int eAddr;
  int obsWrites, obsDones, firstIssue, firstWrite, cycN;

  function automatic int clampOrder(input int o);
    if (o < 1) return 1;
    if (o > 9) return 9;
    return o;
  endfunction

  task automatic modelReset();
    mMode = 0; mNext = 0; mOrder = ORDER_RST; mLast = 0;
    qAddr.delete(); qAge.delete();
  endtask

  task automatic modelCheck();
    bit act;
    act    = (mMode == 1 || mMode == 2) && !iAbort;
    eEn    = act && iOutReady;
    eIssue = eEn && (mMode == 1);
    eWrite = eEn && (qAge.size() > 0) && (qAge[0] == PIPE_LAT);
    eAddr  = eWrite ? qAddr[0] : mLast;
    eDone  = (mMode == 3);
    checkVal("en", oEn, eEn);
    checkVal("issue", oIssue, eIssue);
    checkVal("row", oRow, (mNext % NPIX) / IMG_W);
    checkVal("col", oCol, mNext % IMG_W);
    checkVal("order", oOrder, mOrder);
    checkVal("write", oWrite, eWrite);
    checkVal("wraddr", oWrAddr, eAddr);
    checkVal("busy", oBusy, (mMode == 1 || mMode == 2));
    checkVal("done", oDone, eDone);
  endtask

  task automatic modelAdvance();
    bit wasEmpty;
    wasEmpty = (qAddr.size() == 0);
    case (mMode)
      0: if (iStart && !iAbort) begin
        mMode = 1; mNext = 0; mOrder = clampOrder(int'(iOrder));
      end
      1, 2: begin
        if (iAbort) begin
          mMode = 0; mNext = 0; qAddr.delete(); qAge.delete();
        end else if (eEn) begin
          if (eWrite) begin
            mLast = qAddr.pop_front();
            void'(qAge.pop_front());
          end
          foreach (qAge[i]) qAge[i]++;
          if (eIssue) begin
            qAddr.push_back(mNext);
            qAge.push_back(1);
            mNext++;
            if (mNext == NPIX) mMode = 2;
          end else if (mMode == 2 && wasEmpty) begin
            mMode = 3;
          end
        end
      end
      default: mMode = 0;
    endcase
  endtask

  task automatic cyc(input bit s, input bit a, input int o, input bit r);
    @(posedge iClk);
    #1;
    iStart = s; iAbort = a; iOrder = ORDER_W'(o); iOutReady = r;
    @(negedge iClk);
    modelCheck();
    if (oWrite) obsWrites++;
    if (oDone) obsDones++;
    if (oIssue && firstIssue < 0) firstIssue = cycN;
    if (oWrite && firstWrite < 0) firstWrite = cycN;
    cycN++;
    modelAdvance();
  endtask

  task automatic runFrame(input int order, input int stallPct, input int abortAfter,
                          input bit extraStarts, input int stallAtAddr, input bit doStart);
    int n, stalls, stallLeft;
    bit r, a, s, fin, aborted;
    n = 0; stalls = 0; stallLeft = 0; fin = 0; aborted = 0;
    if (doStart) cyc(1, 0, order, 1);
    obsWrites = 0; obsDones = 0; firstIssue = -1; firstWrite = -1; cycN = 0;
    while (!fin && n < 20000) begin
      r = 1'b1;
      if (stallLeft > 0) begin
        r = 1'b0;
        stallLeft--;
      end else if (stallPct > 0 && $urandom_range(99) < stallPct) begin
        r = 1'b0;
      end
      a = (abortAfter >= 0) && (obsWrites == abortAfter);
      s = extraStarts && ($urandom_range(31) == 0);
      cyc(s, a, int'($urandom_range(15)), r);
      n++;
      if (oDone || eDone) fin = 1'b1;
      else if (a) begin fin = 1'b1; aborted = 1'b1; end
      else if (!r) stalls++;
      if (stallAtAddr >= 0 && oWrite && int'(oWrAddr) == stallAtAddr) stallLeft = 3;
    end
    checkVal("frame_end", fin, 1);
    if (aborted) begin
      repeat (6) cyc(0, 0, 0, 1);
      checkVal("abort_writes", obsWrites, abortAfter);
      checkVal("abort_dones", obsDones, 0);
    end else begin
      checkVal("frame_writes", obsWrites, NPIX);
      checkVal("frame_dones", obsDones, 1);
      checkVal("frame_len", n, NPIX + PIPE_LAT + 2 + stalls);
      if (stallPct == 0) checkVal("first_lat", firstWrite - firstIssue, PIPE_LAT);
      cyc(0, 0, 0, 1);
      checkVal("single_done", obsDones, 1);
    end
  endtask

  task automatic drainReset(input int order);
    int n;
    n = 0;
    cyc(1, 0, order, 1);
    while (mMode != 2 && n < 6000) begin
      cyc(0, 0, 0, 1);
      n++;
    end
    cyc(0, 0, 0, 1);
    checkVal("drain_busy", oBusy, 1);
    @(posedge iClk);
    #3;
    iRst_n = 1'b0; iStart = 1'b1; iOrder = ORDER_W'(2);
    modelReset();
    #1;
    modelCheck();
    repeat (2) begin
      @(negedge iClk);
      modelCheck();
    end
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    @(negedge iClk);
    modelCheck();
    modelAdvance();
    runFrame(0, 0, -1, 0, -1, 0);
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge iClk);
    modelCheck();
    iRst_n = 1'b1;
    runFrame(6, 0, -1, 0, -1, 1);
    checkVal("order6", oOrder, 6);
    runFrame(3, 0, -1, 0, 100, 1);
    runFrame(7, 0, 10, 0, -1, 1);
    runFrame(0, 0, -1, 0, -1, 1);
    checkVal("order0", oOrder, 1);
    runFrame(12, 0, -1, 1, -1, 1);
    checkVal("order12", oOrder, 9);
    drainReset(8);
    checkVal("order_rst_start", oOrder, 2);
    runFrame(int'($urandom_range(15)), 15, -1, 1, -1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
